// File: rtl/buffet_fill_ctrl.sv
// Producer-side credit controller for a single buffet: forwards upstream data to the
// buffet fill port only while locally held credits remain, refreshing them from the credit port.
module buffet_fill_ctrl #(
  parameter int unsigned IDX_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SETTLE_CYCLES  = 3,
  parameter int unsigned REFRESH_THRESH = 0
) (
  input  logic                  clk,
  input  logic                  nreset_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_data_valid,
  input  logic                  push_data_ready,
  output logic                  credit_ready,
  input  logic [IDX_WIDTH-1:0]  credit_out,
  input  logic                  credit_valid,
  output logic [IDX_WIDTH-1:0]  credit_cnt_o,
  output logic [1:0]            state_o,
  output logic [31:0]           push_total_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CREDIT = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] THRESH      = IDX_WIDTH'(REFRESH_THRESH);

  state_t               state, state_n;
  logic [IDX_WIDTH-1:0] credit_cnt, credit_n;
  logic [3:0]           settle_cnt, settle_n;
  logic [31:0]          push_total;
  logic                 go, push;

  assign push_data    = in_data;
  assign credit_cnt_o = credit_cnt;
  assign state_o      = state;
  assign push_total_o = push_total;

  always_comb begin
    go              = (state == S_STREAM) && (credit_cnt != '0);
    push_data_valid = in_valid && go;
    in_ready        = push_data_ready && go;
    push            = push_data_valid && push_data_ready;
    credit_ready    = (state == S_CREDIT);
  end

  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    credit_n = push ? credit_cnt - 1'b1 : credit_cnt;
    unique case (state)
      S_IDLE: begin
        credit_n = '0;
        if (en_i) begin
          state_n  = S_SETTLE;
          settle_n = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (!en_i)                  state_n  = S_IDLE;
        else if (settle_cnt == '0)  state_n  = S_CREDIT;
        else                        settle_n = settle_cnt - 1'b1;
      end
      S_CREDIT: begin
        // A handshake coinciding with en_i low still captures; IDLE clears it next edge.
        if (credit_valid) begin
          credit_n = credit_out;
          state_n  = en_i ? S_STREAM : S_IDLE;
        end else if (!en_i) begin
          state_n = S_IDLE;
        end
      end
      S_STREAM: begin
        if (!en_i) begin
          state_n = S_IDLE;
        end else if (credit_n == '0) begin
          state_n  = S_SETTLE;
          settle_n = SETTLE_LOAD;
        end else if ((REFRESH_THRESH != 0) && (credit_n <= THRESH) && !in_valid) begin
          state_n  = S_SETTLE;
          settle_n = SETTLE_LOAD;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      state      <= S_IDLE;
      credit_cnt <= '0;
      settle_cnt <= '0;
      push_total <= '0;
    end else begin
      state      <= state_n;
      credit_cnt <= credit_n;
      settle_cnt <= settle_n;
      if (push) push_total <= push_total + 32'd1;
    end
  end

endmodule

// File: tb/tb_buffet_fill_ctrl.sv
// Directed bench for buffet_fill_ctrl: credit acquisition, streaming, backpressure,
// buffet-full retry, enable drop and reset during the credit phase.
module tb_buffet_fill_ctrl;

  logic        clk = 1'b0;
  logic        nreset_i;
  logic        en_i;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] push_data;
  logic        push_data_valid;
  logic        push_data_ready;
  logic        credit_ready;
  logic [7:0]  credit_out;
  logic        credit_valid;
  logic [7:0]  credit_cnt_o;
  logic [1:0]  state_o;
  logic [31:0] push_total_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  buffet_fill_ctrl #(
    .IDX_WIDTH      (8),
    .DATA_WIDTH     (32),
    .SETTLE_CYCLES  (3),
    .REFRESH_THRESH (0)
  ) dut (
    .clk             (clk),
    .nreset_i        (nreset_i),
    .en_i            (en_i),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .push_data       (push_data),
    .push_data_valid (push_data_valid),
    .push_data_ready (push_data_ready),
    .credit_ready    (credit_ready),
    .credit_out      (credit_out),
    .credit_valid    (credit_valid),
    .credit_cnt_o    (credit_cnt_o),
    .state_o         (state_o),
    .push_total_o    (push_total_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    nreset_i        = 1'b0;
    en_i            = 1'b0;
    in_data         = 32'hA5A5_0001;
    in_valid        = 1'b0;
    push_data_ready = 1'b0;
    credit_out      = 8'd0;
    credit_valid    = 1'b0;
    tick(2);

    check("rst_state",  32'(state_o), 32'd0);
    check("rst_credit", 32'(credit_cnt_o), 32'd0);
    check("rst_total",  push_total_o, 32'd0);
    check("rst_inrdy",  32'(in_ready), 32'd0);
    check("rst_pdv",    32'(push_data_valid), 32'd0);
    check("rst_crdy",   32'(credit_ready), 32'd0);
    in_data = 32'h1234_5678;
    #1;
    check("data_pass", push_data, 32'h1234_5678);

    // Enable: three SETTLE cycles, then CREDIT
    nreset_i   = 1'b1;
    en_i       = 1'b1;
    credit_out = 8'd16;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("settle_state", 32'(state_o), 32'd1);
      check("settle_crdy",  32'(credit_ready), 32'd0);
    end
    tick();
    check("credit_state", 32'(state_o), 32'd2);
    check("credit_crdy",  32'(credit_ready), 32'd1);
    tick();
    check("credit_wait",  32'(state_o), 32'd2);
    check("credit_crdy2", 32'(credit_ready), 32'd1);
    credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
    check("stream_state", 32'(state_o), 32'd3);
    check("credit_16",    32'(credit_cnt_o), 32'd16);
    check("stream_crdy",  32'(credit_ready), 32'd0);

    // Stream 5 words
    in_valid        = 1'b1;
    push_data_ready = 1'b1;
    #1;
    check("s5_pdv",   32'(push_data_valid), 32'd1);
    check("s5_inrdy", 32'(in_ready), 32'd1);
    tick(5);
    in_valid = 1'b0;
    check("s5_credit", 32'(credit_cnt_o), 32'd11);
    check("s5_total",  push_total_o, 32'd5);
    tick(3);
    check("idle_stream_state",  32'(state_o), 32'd3);
    check("idle_stream_credit", 32'(credit_cnt_o), 32'd11);

    // Backpressure: handshake only on ready cycles
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_data_ready = (i % 2 == 0);
      #1;
      check("bp_inrdy", 32'(in_ready), 32'(i % 2 == 0));
      tick();
    end
    in_valid        = 1'b0;
    push_data_ready = 1'b1;
    check("bp_credit", 32'(credit_cnt_o), 32'd9);
    check("bp_total",  push_total_o, 32'd7);

    // Fill buffet to 16, exhausting the 9 remaining credits
    in_valid = 1'b1;
    tick(9);
    check("full_state",  32'(state_o), 32'd1);
    check("full_credit", 32'(credit_cnt_o), 32'd0);
    check("full_total",  push_total_o, 32'd16);
    check("full_inrdy",  32'(in_ready), 32'd0);
    tick(3);
    check("full_cr_state", 32'(state_o), 32'd2);
    credit_out   = 8'd0;
    credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
    check("zero_state", 32'(state_o), 32'd3);
    check("zero_pdv",   32'(push_data_valid), 32'd0);
    check("zero_inrdy", 32'(in_ready), 32'd0);
    tick();
    check("retry_state", 32'(state_o), 32'd1);

    // Consumer shrinks 8: next refresh grants 8
    credit_out = 8'd8;
    tick(3);
    check("retry_cr_state", 32'(state_o), 32'd2);
    credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
    check("refill_credit", 32'(credit_cnt_o), 32'd8);
    tick(4);
    in_valid = 1'b0;
    check("refill_total",  push_total_o, 32'd20);
    check("refill_credit", 32'(credit_cnt_o), 32'd4);

    // en_i drop on a push cycle
    in_valid = 1'b1;
    en_i     = 1'b0;
    #1;
    check("endrop_pdv", 32'(push_data_valid), 32'd1);
    tick();
    check("endrop_state", 32'(state_o), 32'd0);
    check("endrop_total", push_total_o, 32'd21);
    check("endrop_pdv2",  32'(push_data_valid), 32'd0);
    tick();
    check("endrop_credit", 32'(credit_cnt_o), 32'd0);
    check("endrop_pdv3",   32'(push_data_valid), 32'd0);
    check("endrop_total2", push_total_o, 32'd21);
    in_valid = 1'b0;

    // Reset asserted in CREDIT with credit_valid high
    en_i = 1'b1;
    tick(4);
    check("rc_state", 32'(state_o), 32'd2);
    credit_out   = 8'd5;
    credit_valid = 1'b1;
    #1;
    nreset_i = 1'b0;
    #1;
    check("rc_state0", 32'(state_o), 32'd0);
    check("rc_credit", 32'(credit_cnt_o), 32'd0);
    check("rc_crdy",   32'(credit_ready), 32'd0);
    check("rc_total",  push_total_o, 32'd0);
    tick();
    check("rc_credit2", 32'(credit_cnt_o), 32'd0);
    check("rc_state2",  32'(state_o), 32'd0);
    credit_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/buffet_fill_ctrl.md
Name: buffet_fill_ctrl

Overview:
- Producer-side credit controller for a single buffet.
- Sits between an upstream valid/ready data stream and the buffet fill port (push_data/push_data_valid/push_data_ready).
- Obtains free-space snapshots from the buffet credit port (credit_ready/credit_valid/credit_out) and forwards upstream data only while locally held credits remain, so the buffet is never overfilled.
- Sequences the credit-refresh/stream cycle and exposes status counters.

Parameters:
- IDX_WIDTH, 8: buffet index and credit width; buffet SIZE < 2^IDX_WIDTH.
- DATA_WIDTH, 32: fill data width.
- SETTLE_CYCLES, 3: quiet cycles after the last push before requesting credit, so the buffet snapshot reflects all pushes; range 1..15.
- REFRESH_THRESH, 0: STREAM also exits to refresh when credit_cnt <= REFRESH_THRESH and upstream is not valid; 0 disables this early exit.

Ports:
- clk  in  1  clock, rising edge.
- nreset_i  in  1  asynchronous active-low reset.
- en_i  in  1  enable; low forces the return to IDLE.
- in_data  in  DATA_WIDTH  upstream data.
- in_valid  in  1  upstream valid.
- in_ready  out  1  upstream ready.
- push_data  out  DATA_WIDTH  to buffet fill data.
- push_data_valid  out  1  to buffet fill valid.
- push_data_ready  in  1  from buffet fill ready.
- credit_ready  out  1  to buffet credit ready.
- credit_out  in  IDX_WIDTH  buffet free-space snapshot.
- credit_valid  in  1  buffet credit valid.
- credit_cnt_o  out  IDX_WIDTH  currently held credits.
- state_o  out  2  FSM state: IDLE=0, SETTLE=1, CREDIT=2, STREAM=3.
- push_total_o  out  32  total pushes since reset, wraps.

Behaviour:
- One clock; reset is asynchronous and active-low on nreset_i.
- Reset values:
  - state IDLE, credit_cnt 0, settle counter 0, push_total 0.
  - All outputs 0: in_ready, push_data_valid, credit_ready.
  - push_data follows in_data combinationally.
- Push gating: go = (state==STREAM) && (credit_cnt!=0).
  - push_data_valid = in_valid && go.
  - in_ready = push_data_ready && go.
  - Zero-latency pass-through; a push occurs on a cycle where push_data_valid && push_data_ready.
- Each push: credit_cnt -= 1 and push_total += 1 at the next edge. credit_cnt never underflows, because go requires credit_cnt != 0.
- IDLE:
  - credit_cnt held at 0.
  - en_i high -> SETTLE, with the settle counter loaded to SETTLE_CYCLES-1.
- SETTLE:
  - No pushes and credit_ready=0.
  - Counter decrements each cycle; at 0 -> CREDIT.
  - en_i low -> IDLE.
- CREDIT:
  - credit_ready=1 until credit_valid is sampled high.
  - On the handshake edge: credit_cnt <= credit_out (absolute snapshot, replaces the old value), then -> STREAM.
  - en_i low with no handshake that cycle -> IDLE. With a simultaneous handshake, the credit is captured and the next state is IDLE, which clears credit_cnt on the following edge.
- STREAM exits, evaluated after the push update of that cycle:
  - (a) credit_cnt reaches 0 -> SETTLE.
  - (b) REFRESH_THRESH!=0, credit_cnt_next <= REFRESH_THRESH and in_valid==0 -> SETTLE.
  - (c) en_i low -> IDLE; a push handshaking in that same cycle completes and is counted.
  - Precedence: (c) > (a) > (b).
- Credit zero case: credit_out==0 captured -> STREAM with credit_cnt 0 -> next cycle SETTLE. There are no pushes, and the controller retries indefinitely.
- Snapshot rule: credit is only requested after SETTLE_CYCLES with no pushes, so credit_out equals true free space; held credits are discarded on refresh.
- Wrap: push_total wraps modulo 2^32 without saturation.
- Reset mid-operation: immediate return to reset values; an in-flight push is abandoned (the upstream must not assume acceptance).

Test Plan:
- Reset, en_i=1, buffet empty (SIZE=16):
  - state 0->1 (3 cycles) ->2 ->3.
  - credit_cnt_o=16 after the handshake.
  - credit_ready high for exactly the CREDIT cycles.
- Stream 5 words, upstream continuous valid:
  - 5 consecutive pushes, credit_cnt_o 16->11, push_total_o=5.
  - Then drop in_valid: no change with REFRESH_THRESH=0.
- Stream 20 words into SIZE=16, no consumer shrink:
  - exactly 16 pushes, then SETTLE; refresh returns 0; in_ready stays 0.
  - Shrink 8 at the buffet -> next refresh credit 8 -> remaining 4 words pushed, push_total_o=20.
- Backpressure: push_data_ready toggling 1/0 with in_valid=1 -> credits decrement only on handshake cycles; in_ready mirrors push_data_ready while in STREAM.
- en_i deasserted mid-STREAM on a push cycle -> that push is counted, next state IDLE, credit_cnt_o=0, and no further push_data_valid.
- nreset_i pulsed low in CREDIT with credit_valid high -> immediate state 0, credit_cnt_o=0, credit_ready=0, and no credit captured.
